// File: rtl/hwjsoc_sysid_checker.sv
// Reads the ID and build-timestamp words from a sysid slave over Avalon-MM and
// compares them with the expected values, with a per-read waitrequest timeout.
module hwjsoc_sysid_checker #(
  parameter logic [31:0]  EXPECTED_ID    = 32'd16,
  parameter logic [31:0]  EXPECTED_TS    = 32'd1589565123,
  parameter int unsigned  TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      stall_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
            stall_cnt   <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end

        RD_ID: begin
          if (avm_waitrequest) begin
            // The stalled edge that hits the limit abandons the read outright.
            if (stall_cnt == STALL_LAST) begin
              state       <= FINISH;
              avm_read    <= 1'b0;
              avm_address <= 1'b0;
              timeout     <= 1'b1;
              done        <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else begin
            state       <= RD_TS;
            id_value    <= avm_readdata;
            id_ok       <= (avm_readdata == EXPECTED_ID);
            avm_address <= 1'b1;
            stall_cnt   <= '0;
          end
        end

        RD_TS: begin
          if (avm_waitrequest) begin
            if (stall_cnt == STALL_LAST) begin
              state       <= FINISH;
              avm_read    <= 1'b0;
              avm_address <= 1'b0;
              timeout     <= 1'b1;
              done        <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else begin
            state       <= FINISH;
            ts_value    <= avm_readdata;
            ts_ok       <= (avm_readdata == EXPECTED_TS);
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            done        <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwjsoc_sysid_checker.sv
// Bench for hwjsoc_sysid_checker: scripted sysid slave with per-read stall
// counts, results predicted from the read/timeout rules in plain arithmetic.
module tb_hwjsoc_sysid_checker;

  localparam int unsigned T   = 4;
  localparam logic [31:0] EID = 32'd16;
  localparam logic [31:0] ETS = 32'd1589565123;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata, id_value, ts_value;
  logic        busy, done, id_ok, ts_ok, timeout;

  always #5 clock = ~clock;

  hwjsoc_sysid_checker #(
    .EXPECTED_ID   (EID),
    .EXPECTED_TS   (ETS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rem [2];
  logic [31:0] word [2];
  int          done_cnt, done_cyc, read_cycles;
  bit          ts_issued;
  bit          prev_stall = 1'b0;
  logic        prev_addr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe DUT outputs mid-cycle, then present the slave response.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (prev_stall && !timeout && !reset) begin
      chk("stall_read_stable", 32'(avm_read), 32'd1);
      chk("stall_addr_stable", 32'(avm_address), 32'(prev_addr));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (avm_read === 1'b1) begin
      read_cycles++;
      if (avm_address === 1'b1) ts_issued = 1'b1;
    end
    if (avm_read === 1'b1 && rem[avm_address] > 0) begin
      avm_waitrequest = 1'b1;
      rem[avm_address]--;
      avm_readdata = $urandom;
    end else begin
      avm_waitrequest = 1'b0;
      avm_readdata = (avm_read === 1'b1) ? word[avm_address] : $urandom;
    end
    prev_stall = (avm_read === 1'b1) && avm_waitrequest;
    prev_addr  = avm_address;
  endtask

  // noise: 0 = start idle during run, 1 = random start, 2 = start held high
  task automatic run_seq(input int sid, input int sts, input logic [31:0] idw,
                         input logic [31:0] tsw, input int noise);
    bit id_to, ts_to;
    int exp_reads, c0;
    id_to     = (sid >= int'(T));
    ts_to     = !id_to && (sts >= int'(T));
    exp_reads = id_to ? int'(T) : sid + 1 + (ts_to ? int'(T) : sts + 1);
    rem[0] = sid;  rem[1] = sts;
    word[0] = idw; word[1] = tsw;
    done_cnt = 0; done_cyc = -1; read_cycles = 0; ts_issued = 1'b0;

    start = 1'b1;
    c0 = cyc;
    tick();
    start = (noise == 2);
    chk("first_read", 32'({avm_read, avm_address}), 32'b10);
    chk("busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      if (noise == 1) start = 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_cyc - c0), 32'(exp_reads + 1));
    chk("read_cycles", 32'(read_cycles), 32'(exp_reads));
    chk("ts_read_issued", 32'(ts_issued), 32'(!id_to));
    chk("busy_finish", 32'(busy), 32'd1);
    chk("timeout", 32'(timeout), 32'(id_to || ts_to));
    chk("id_ok", 32'(id_ok), 32'(!id_to && idw == EID));
    chk("ts_ok", 32'(ts_ok), 32'(!id_to && !ts_to && tsw == ETS));
    chk("id_value", id_value, id_to ? 32'd0 : idw);
    chk("ts_value", ts_value, (id_to || ts_to) ? 32'd0 : tsw);

    start = (noise != 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("idle_after", 32'({busy, avm_read}), 32'd0);
    chk("hold_id", id_value, id_to ? 32'd0 : idw);
    chk("hold_ts", ts_value, (id_to || ts_to) ? 32'd0 : tsw);
    chk("hold_flags", 32'({id_ok, ts_ok, timeout}),
        32'({!id_to && idw == EID, !id_to && !ts_to && tsw == ETS, id_to || ts_to}));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    rem[0] = 0; rem[1] = 0; word[0] = '0; word[1] = '0;
    tick(); tick();
    chk("reset_ctrl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    chk("reset_vals", id_value | ts_value, 32'd0);
    reset = 1'b0;
    tick();

    run_seq(0, 0, EID, ETS, 0);           // nominal, minimum latency
    run_seq(0, 0, 32'd17, ETS, 0);        // wrong ID
    run_seq(3, 3, EID, ETS, 0);           // stall one below the limit on each read
    run_seq(1000, 0, EID, ETS, 0);        // permanent stall on ID read
    run_seq(0, 4, EID, ETS, 0);           // stall exactly at limit on timestamp read
    run_seq(1, 2, EID, ETS, 2);           // start held through RD_TS and FINISH

    // Reset while the timestamp read is stalled.
    rem[0] = 0; rem[1] = 1000; word[0] = EID; word[1] = ETS;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !(avm_read === 1'b1 && avm_address === 1'b1); i++) tick();
    chk("reached_rd_ts", 32'({avm_read, avm_address}), 32'b11);
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("midrd_reset_ctrl", 32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}), 32'd0);
    chk("midrd_reset_vals", id_value | ts_value, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("midrd_no_done", 32'(done_cnt), 32'd0);
    chk("midrd_idle", 32'(busy), 32'd0);
    run_seq(0, 0, EID, ETS, 0);

    for (int k = 0; k < 12; k++) begin
      run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom_range(0, 1) ? EID : $urandom,
              $urandom_range(0, 1) ? ETS : $urandom,
              int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
